// File: rtl/seq_shift_add_multiplier.sv
// Unsigned sequential shift-and-add multiplier with a start/busy/done handshake.
// Define EARLY_TERM_EN to leave RUN as soon as the remaining multiplier bits are all zero.
module seq_shift_add_multiplier #(
   parameter int unsigned A_WIDTH = 4,
   parameter int unsigned B_WIDTH = 3
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [A_WIDTH-1:0]         A,
   input  logic [B_WIDTH-1:0]         B,
   output logic                       busy,
   output logic                       done,
   output logic [A_WIDTH+B_WIDTH-1:0] product
);

   localparam int unsigned PW = A_WIDTH + B_WIDTH;
   localparam int unsigned CW = $clog2(B_WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   logic [PW-1:0]       acc;
   logic [PW-1:0]       mcand;
   logic [B_WIDTH-1:0]  mplier;
   logic [CW-1:0]       cnt;
   logic [PW-1:0]       acc_sum;
   logic                last_step;

   // Partial-product add for the current multiplier bit and the RUN exit condition.
   always_comb begin
      acc_sum   = mplier[0] ? (acc + mcand) : acc;
      last_step = (cnt == CW'(1));
`ifdef EARLY_TERM_EN
      if (mplier[B_WIDTH-1:1] == '0) begin
         last_step = 1'b1;
      end
`else
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         cnt     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state  <= RUN;
                  busy   <= 1'b1;
                  acc    <= '0;
                  mcand  <= {{B_WIDTH{1'b0}}, A};
                  mplier <= B;
                  cnt    <= CW'(B_WIDTH);
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            RUN: begin
               acc    <= acc_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - CW'(1);
               // Final step: publish the result and pulse done for one cycle.
               if (last_step) begin
                  state   <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  product <= acc_sum;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier: randomized and directed operations
// checked against a plain A*B model and the busy-latency rule of the active build.
module tb_seq_shift_add_multiplier;

   localparam int unsigned AW = 4;
   localparam int unsigned BW = 3;
   localparam int unsigned PW = AW + BW;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] A;
   logic [BW-1:0] B;
   logic          busy;
   logic          done;
   logic [PW-1:0] product;

   int checks;
   int passed;

   seq_shift_add_multiplier #(
      .A_WIDTH(AW),
      .B_WIDTH(BW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .A       (A),
      .B       (B),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: expected number of busy cycles for a given multiplier value.
   function automatic int exp_busy(input int b);
      int n;
`ifdef EARLY_TERM_EN
      n = 1;
      for (int i = 0; i < int'(BW); i++) begin
         if (((b >> i) & 1) != 0) n = i + 1;
      end
`else
      n = int'(BW);
`endif
      return n;
   endfunction

   function automatic logic [PW-1:0] exp_prod(input int a, input int b);
      int p;
      p = a * b;
      return PW'(p);
   endfunction

   // Issue one operation (start sampled at the next edge) and follow it to its done cycle.
   task automatic do_op(input logic [AW-1:0] a, input logic [BW-1:0] b,
                        output int nbusy, output logic [PW-1:0] prod,
                        output bit tmo, output bit unstable, output bit overlap);
      logic [PW-1:0] prev;
      prev     = product;
      nbusy    = 0;
      tmo      = 1'b1;
      unstable = 1'b0;
      overlap  = 1'b0;
      prod     = '0;
      A        = a;
      B        = b;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      A     = AW'($urandom);
      B     = BW'($urandom);
      for (int i = 0; i < 20; i++) begin
         if (busy && done) overlap = 1'b1;
         if (done) begin
            tmo  = 1'b0;
            prod = product;
            break;
         end
         if (busy) begin
            nbusy++;
            if (product !== prev) unstable = 1'b1;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      A     = 4'd15;
      B     = 3'd7;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
      else passed++;
      checks++;
      if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done);
      else passed++;
      checks++;
      if (product !== '0) $display("FAIL reset_product: got %0d want 0", product);
      else passed++;
      start = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int nb; logic [PW-1:0] p; bit tmo, uns, ovl;
      do_op(4'd15, 3'd7, nb, p, tmo, uns, ovl);
      checks++;
      if (tmo) $display("FAIL basic_timeout: no done within bound");
      else passed++;
      checks++;
      if (p !== 7'd105) $display("FAIL basic_product: got %0d want 105", p);
      else passed++;
      checks++;
      if (nb != 3) $display("FAIL basic_busy_cycles: got %0d want 3", nb);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) $display("FAIL basic_done_width: got %b want 0", done);
      else passed++;
   endtask

   task automatic test_zero();
      int nb; logic [PW-1:0] p; bit tmo, uns, ovl;
      do_op(4'd9, 3'd0, nb, p, tmo, uns, ovl);
      checks++;
      if (tmo || p !== '0) $display("FAIL zero_b_product: got %0d want 0 (timeout=%0b)", p, tmo);
      else passed++;
      checks++;
      if (nb != exp_busy(0)) $display("FAIL zero_b_busy_cycles: got %0d want %0d", nb, exp_busy(0));
      else passed++;
      @(posedge clk); #1;
      do_op(4'd0, 3'd5, nb, p, tmo, uns, ovl);
      checks++;
      if (tmo || p !== '0) $display("FAIL zero_a_product: got %0d want 0 (timeout=%0b)", p, tmo);
      else passed++;
      checks++;
      if (nb != exp_busy(5)) $display("FAIL zero_a_busy_cycles: got %0d want %0d", nb, exp_busy(5));
      else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int nb; logic [PW-1:0] p; bit tmo, uns, ovl;
      do_op(4'd6, 3'd5, nb, p, tmo, uns, ovl);
      checks++;
      if (tmo || p !== 7'd30) $display("FAIL b2b_first_product: got %0d want 30 (timeout=%0b)", p, tmo);
      else passed++;
      // Second start issued in the done cycle; an IDLE gap would stall and time out.
      do_op(4'd3, 3'd2, nb, p, tmo, uns, ovl);
      checks++;
      if (tmo || p !== 7'd6) $display("FAIL b2b_second_product: got %0d want 6 (timeout=%0b)", p, tmo);
      else passed++;
      checks++;
      if (uns) $display("FAIL b2b_product_hold: product moved during second run, want 30 held");
      else passed++;
      checks++;
      if (nb != exp_busy(2)) $display("FAIL b2b_busy_cycles: got %0d want %0d", nb, exp_busy(2));
      else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_start_held();
      bit seen;
      int nb;
      seen  = 1'b0;
      nb    = 0;
      A     = 4'd12;
      B     = 3'd3;
      start = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         if (done) begin
            seen  = 1'b1;
            start = 1'b0;
            break;
         end
         if (busy) nb++;
         A = AW'($urandom);
         B = BW'($urandom);
         @(posedge clk); #1;
      end
      checks++;
      if (!seen || product !== 7'd36) $display("FAIL held_start_product: got %0d want 36 (done=%0b)", product, seen);
      else passed++;
      checks++;
      if (nb != exp_busy(3)) $display("FAIL held_start_busy_cycles: got %0d want %0d", nb, exp_busy(3));
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) $display("FAIL held_start_idle: busy=%b done=%b want 0 0", busy, done);
      else passed++;
   endtask

   task automatic test_mid_reset();
      int nb; logic [PW-1:0] p; bit tmo, uns, ovl;
      A     = 4'd11;
      B     = 3'd7;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== '0)
         $display("FAIL midrun_reset: busy=%b done=%b product=%0d want 0 0 0", busy, done, product);
      else passed++;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         checks++;
         if (busy !== 1'b0 || done !== 1'b0) $display("FAIL midrun_reset_idle: busy=%b done=%b want 0 0", busy, done);
         else passed++;
      end
      do_op(4'd5, 3'd5, nb, p, tmo, uns, ovl);
      checks++;
      if (tmo || p !== 7'd25) $display("FAIL midrun_reset_next: got %0d want 25 (timeout=%0b)", p, tmo);
      else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_sweep();
      int nb; logic [PW-1:0] p; bit tmo, uns, ovl;
      for (int a = 0; a < (1 << AW); a++) begin
         for (int b = 0; b < (1 << BW); b++) begin
            do_op(AW'(a), BW'(b), nb, p, tmo, uns, ovl);
            checks++;
            if (tmo || p !== exp_prod(a, b))
               $display("FAIL sweep_product a=%0d b=%0d: got %0d want %0d (timeout=%0b)", a, b, p, exp_prod(a, b), tmo);
            else passed++;
            checks++;
            if (nb != exp_busy(b)) $display("FAIL sweep_busy a=%0d b=%0d: got %0d want %0d", a, b, nb, exp_busy(b));
            else passed++;
            checks++;
            if (uns || ovl) $display("FAIL sweep_flags a=%0d b=%0d: unstable=%0b overlap=%0b want 0 0", a, b, uns, ovl);
            else passed++;
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0)
               $display("FAIL sweep_done_pulse a=%0d b=%0d: busy=%b done=%b want 0 0", a, b, busy, done);
            else passed++;
         end
      end
   endtask

   task automatic test_random();
      int nb; logic [PW-1:0] p; bit tmo, uns, ovl;
      int a, b;
      for (int n = 0; n < 40; n++) begin
         a = int'($urandom_range((1 << AW) - 1, 0));
         b = int'($urandom_range((1 << BW) - 1, 0));
         do_op(AW'(a), BW'(b), nb, p, tmo, uns, ovl);
         checks++;
         if (tmo || p !== exp_prod(a, b) || nb != exp_busy(b))
            $display("FAIL random a=%0d b=%0d: got %0d/%0d busy want %0d/%0d (timeout=%0b)",
                     a, b, p, nb, exp_prod(a, b), exp_busy(b), tmo);
         else passed++;
         // Randomly chain the next op from the done cycle or idle for a few cycles.
         if ($urandom_range(1, 0) == 0) begin
            repeat ($urandom_range(3, 1)) @(posedge clk);
            #1;
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      checks = 0;
      passed = 0;
      rst_n  = 1'b0;
      start  = 1'b0;
      A      = '0;
      B      = '0;
      test_reset();
      test_basic();
      test_zero();
      test_back_to_back();
      test_start_held();
      test_mid_reset();
      test_sweep();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
